// File: rtl/sram_responder.sv
// sram_responder: clocked emulator of a 256Kx16 asynchronous SRAM with byte lanes and a
// stable-address read latency. Define SRAM_RESP_CHECK_EN to compile in the protocol checker.
module sram_responder #(
    parameter int MEM_WORDS = 4096,
    parameter int READ_LAT  = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [17:0] i_sram_addr,
    input  logic [15:0] i_sram_dq,
    output logic [15:0] o_sram_dq,
    output logic        o_sram_dq_oe,
    input  logic        i_sram_cen,
    input  logic        i_sram_wen,
    input  logic        i_sram_oen,
    input  logic        i_sram_lbn,
    input  logic        i_sram_ubn,
    output logic [2:0]  o_err,
    output logic [1:0]  o_dbg_state
);

    localparam int         AW  = $clog2(MEM_WORDS);
    localparam logic [3:0] LAT = 4'(READ_LAT);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WR_ACTIVE = 2'd1;
    localparam logic [1:0] ST_RD_WAIT   = 2'd2;
    localparam logic [1:0] ST_RD_VALID  = 2'd3;

    // Pin protocol: all pins are active-low levels sampled on every rising edge; there is no
    // handshake, so a read is "accepted" only once addr has been stable for READ_LAT edges.
    logic [1:0]    state, state_nx;
    logic [3:0]    cnt, cnt_nx;
    logic [AW-1:0] addr_idx;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] hold_addr;
    logic [15:0]   hold_dq;
    logic          hold_lbn, hold_ubn;
    logic          in_read, commit;
    logic [15:0]   mem_rd, rd_lanes;
    logic [15:0]   mem [MEM_WORDS];

    assign addr_idx = i_sram_addr[AW-1:0];

    generate
        if (AW < 18) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^i_sram_addr[17:AW];
        end
    endgenerate

    assign in_read = (state == ST_RD_WAIT) || (state == ST_RD_VALID);

    always_comb begin
        state_nx = ST_IDLE;
        cnt_nx   = 4'd0;
        if (i_sram_cen) begin
            state_nx = ST_IDLE;
        end else if (!i_sram_wen) begin
            state_nx = ST_WR_ACTIVE;
        end else if (!i_sram_oen) begin
            if (!in_read || (addr_idx != rd_addr)) begin
                state_nx = ST_RD_WAIT;
                cnt_nx   = 4'd1;
            end else if (state == ST_RD_VALID) begin
                state_nx = ST_RD_VALID;
                cnt_nx   = cnt;
            end else if (cnt == LAT) begin
                state_nx = ST_RD_VALID;
                cnt_nx   = cnt;
            end else begin
                state_nx = ST_RD_WAIT;
                cnt_nx   = cnt + 4'd1;
            end
        end
    end

    // A WE-controlled write lands only when the write phase ends; reset forces IDLE first,
    // so a write interrupted by reset never commits.
    assign commit = (state == ST_WR_ACTIVE) && (state_nx != ST_WR_ACTIVE);

    assign mem_rd   = mem[addr_idx];
    assign rd_lanes = {i_sram_ubn ? 8'h00 : mem_rd[15:8],
                       i_sram_lbn ? 8'h00 : mem_rd[7:0]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            rd_addr   <= '0;
            hold_addr <= '0;
            hold_dq   <= 16'h0000;
            hold_lbn  <= 1'b0;
            hold_ubn  <= 1'b0;
            o_sram_dq <= 16'h0000;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if ((state_nx == ST_RD_WAIT) || (state_nx == ST_RD_VALID)) begin
                rd_addr <= addr_idx;
            end
            if (state_nx == ST_WR_ACTIVE) begin
                hold_addr <= addr_idx;
                hold_dq   <= i_sram_dq;
                hold_lbn  <= i_sram_lbn;
                hold_ubn  <= i_sram_ubn;
            end
            o_sram_dq <= (state_nx == ST_RD_VALID) ? rd_lanes : 16'h0000;
        end
    end

    // Backing store has no reset: contents survive i_rst_n like a real SRAM.
    always_ff @(posedge i_clk) begin
        if (commit && !hold_lbn) begin
            mem[hold_addr][7:0] <= hold_dq[7:0];
        end
        if (commit && !hold_ubn) begin
            mem[hold_addr][15:8] <= hold_dq[15:8];
        end
    end

    assign o_sram_dq_oe = (state == ST_RD_VALID);
    assign o_dbg_state  = state;

`ifdef SRAM_RESP_CHECK_EN
    logic [2:0] err_q, err_set;

    always_comb begin
        err_set    = 3'b000;
        err_set[0] = !i_sram_cen && !i_sram_wen && !i_sram_oen;
        err_set[1] = (state == ST_WR_ACTIVE) && (state_nx == ST_WR_ACTIVE) &&
                     (addr_idx != hold_addr);
        err_set[2] = commit && hold_lbn && hold_ubn;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_q <= 3'b000;
        end else begin
            err_q <= err_q | err_set;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 3'b000;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: reset checks, a directed vector table, reset corner cases,
// randomized traffic against a behavioural SRAM model, and the o_err checker.
module tb_sram_responder;

    localparam int MEM_WORDS = 4096;
    localparam int READ_LAT  = 2;

`ifdef SRAM_RESP_CHECK_EN
    localparam logic [2:0] EXP_CONTENTION = 3'b001;
`else
    localparam logic [2:0] EXP_CONTENTION = 3'b000;
`endif

    // ---------------- clock / reset / pins ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic [17:0] addr;
    logic [15:0] dq_w;
    logic        cen, wen, oen, lbn, ubn;
    logic [15:0] dq_r;
    logic        dq_oe;
    logic [2:0]  err;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    sram_responder #(.MEM_WORDS(MEM_WORDS), .READ_LAT(READ_LAT)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_sram_addr (addr),
        .i_sram_dq   (dq_w),
        .o_sram_dq   (dq_r),
        .o_sram_dq_oe(dq_oe),
        .i_sram_cen  (cen),
        .i_sram_wen  (wen),
        .i_sram_oen  (oen),
        .i_sram_lbn  (lbn),
        .i_sram_ubn  (ubn),
        .o_err       (err),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input int idx, input logic [31:0] got,
                         input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s[%0d]: got 0x%0h, want 0x%0h", name, idx, got, want);
    endtask

    // ---------------- behavioural SRAM model ----------------
    // The model thinks in terms of "was the previous edge a write" and "how many consecutive
    // edges has this read address been held", not in terms of a state machine.
    logic [15:0] m_mem [MEM_WORDS];
    logic        m_wr_prev;
    logic [11:0] m_wa;
    logic [15:0] m_wd;
    logic        m_wl, m_wu;
    int          m_run;
    logic [11:0] m_raddr;
    logic [2:0]  m_err;
    logic        m_exp_oe;
    logic [15:0] m_exp_dq;

    function automatic logic [15:0] lanes(input logic [15:0] w, input logic l, input logic u);
        return {u ? 8'h00 : w[15:8], l ? 8'h00 : w[7:0]};
    endfunction

    task automatic m_reset();
        m_wr_prev = 1'b0;
        m_run     = 0;
        m_err     = 3'b000;
    endtask

    // One rising edge: advance the model with the pins the DUT samples, then settle.
    task automatic step();
        logic        wr, rd;
        logic [11:0] a;
        @(posedge clk);
        a  = addr[11:0];
        wr = !cen && !wen;
        rd = !cen && wen && !oen;
        if (m_wr_prev && !wr) begin
            if (!m_wl) m_mem[m_wa][7:0]  = m_wd[7:0];
            if (!m_wu) m_mem[m_wa][15:8] = m_wd[15:8];
        end
`ifdef SRAM_RESP_CHECK_EN
        if (!cen && !wen && !oen) m_err[0] = 1'b1;
        if (m_wr_prev && wr && (a != m_wa)) m_err[1] = 1'b1;
        if (m_wr_prev && !wr && m_wl && m_wu) m_err[2] = 1'b1;
`endif
        if (rd) begin
            if (m_run > 0 && a == m_raddr) m_run++;
            else m_run = 1;
            m_raddr = a;
        end else begin
            m_run = 0;
        end
        if (wr) begin
            m_wa = a; m_wd = dq_w; m_wl = lbn; m_wu = ubn;
        end
        m_wr_prev = wr;
        m_exp_oe  = rd && (m_run > READ_LAT);
        m_exp_dq  = m_exp_oe ? lanes(m_mem[a], lbn, ubn) : 16'h0000;
        #1;
    endtask

    task automatic set_pins(input logic c, input logic w, input logic o, input logic l,
                            input logic u, input logic [17:0] a, input logic [15:0] d);
        cen = c; wen = w; oen = o; lbn = l; ubn = u; addr = a; dq_w = d;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        cen, wen, oen, lbn, ubn;
        logic [17:0] addr;
        logic [15:0] dq;
        logic        exp_oe;
        logic [15:0] exp_dq;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic c, input logic w, input logic o, input logic l,
                       input logic u, input logic [17:0] a, input logic [15:0] d,
                       input logic eoe, input logic [15:0] edq);
        vec_t v;
        v.cen = c; v.wen = w; v.oen = o; v.lbn = l; v.ubn = u;
        v.addr = a; v.dq = d; v.exp_oe = eoe; v.exp_dq = edq;
        tbl.push_back(v);
    endtask

    initial begin
        logic [31:0] e;
        // write BEEF then read straight out of the write (commit and read start share an edge)
        add(0,0,1,0,0,18'h00010,16'hBEEF,0,16'h0000);
        add(0,0,1,0,0,18'h00010,16'hBEEF,0,16'h0000);
        add(0,1,0,0,0,18'h00010,16'h0000,0,16'h0000);
        add(0,1,0,0,0,18'h00010,16'h0000,0,16'h0000);
        add(0,1,0,0,0,18'h00010,16'h0000,1,16'hBEEF);
        add(1,1,1,0,0,18'h00010,16'h0000,0,16'h0000);
        // byte lanes: AB00 then lower-lane 1234 -> AB34; read with lbn high, then both lanes
        add(0,0,1,0,0,18'h00005,16'hAB00,0,16'h0000);
        add(0,1,1,0,0,18'h00005,16'h0000,0,16'h0000);
        add(0,0,1,0,1,18'h00005,16'h1234,0,16'h0000);
        add(0,1,1,0,1,18'h00005,16'h0000,0,16'h0000);
        add(0,1,0,1,0,18'h00005,16'h0000,0,16'h0000);
        add(0,1,0,1,0,18'h00005,16'h0000,0,16'h0000);
        add(0,1,0,1,0,18'h00005,16'h0000,1,16'hAB00);
        add(0,1,0,0,0,18'h00005,16'h0000,1,16'hAB34);
        add(1,1,1,0,0,18'h00005,16'h0000,0,16'h0000);
        // address change one edge before valid restarts the latency count
        add(0,0,1,0,0,18'h00003,16'h3333,0,16'h0000);
        add(0,1,1,0,0,18'h00003,16'h0000,0,16'h0000);
        add(0,0,1,0,0,18'h00004,16'h4444,0,16'h0000);
        add(0,1,1,0,0,18'h00004,16'h0000,0,16'h0000);
        add(0,1,0,0,0,18'h00003,16'h0000,0,16'h0000);
        add(0,1,0,0,0,18'h00003,16'h0000,0,16'h0000);
        add(0,1,0,0,0,18'h00004,16'h0000,0,16'h0000);
        add(0,1,0,0,0,18'h00004,16'h0000,0,16'h0000);
        add(0,1,0,0,0,18'h00004,16'h0000,1,16'h4444);
        add(0,1,0,0,0,18'h00003,16'h0000,0,16'h0000);
        add(1,1,1,0,0,18'h00003,16'h0000,0,16'h0000);
        // address wrap: 18'h01005 aliases word 5
        add(0,0,1,0,0,18'h01005,16'h5555,0,16'h0000);
        add(0,1,1,0,0,18'h01005,16'h0000,0,16'h0000);
        add(0,1,0,0,0,18'h00005,16'h0000,0,16'h0000);
        add(0,1,0,0,0,18'h00005,16'h0000,0,16'h0000);
        add(0,1,0,0,0,18'h00005,16'h0000,1,16'h5555);
        add(0,1,1,0,0,18'h00005,16'h0000,0,16'h0000);

        // ---------------- reset with random pins ----------------
        rst_n = 1'b0;
        m_reset();
        for (int i = 0; i < 4; i++) begin
            set_pins(1'($urandom_range(0,1)), 1'($urandom_range(0,1)), 1'($urandom_range(0,1)),
                     1'($urandom_range(0,1)), 1'($urandom_range(0,1)), 18'($urandom),
                     16'($urandom));
            @(posedge clk); #1;
            check("rst_dq", i, 32'(dq_r), 32'h0);
            check("rst_oe", i, 32'(dq_oe), 32'h0);
            check("rst_err", i, 32'(err), 32'h0);
            check("rst_state", i, 32'(dbg_state), 32'h0);
        end
        set_pins(1,1,0,0,0,18'h00010,16'h0000);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_oe", i, 32'(dq_oe), 32'h0);
            check("idle_state", i, 32'(dbg_state), 32'h0);
        end

        // ---------------- table ----------------
        foreach (tbl[i]) begin
            set_pins(tbl[i].cen, tbl[i].wen, tbl[i].oen, tbl[i].lbn, tbl[i].ubn,
                     tbl[i].addr, tbl[i].dq);
            step();
            check("tbl_oe", i, 32'(dq_oe), 32'(tbl[i].exp_oe));
            check("tbl_dq", i, 32'(dq_r), 32'(tbl[i].exp_dq));
        end

        // ---------------- reset during a read drops oe at once ----------------
        set_pins(0,1,0,0,0,18'h00004,16'h0000);
        for (int i = 0; i < 3; i++) step();
        check("rdrst_pre_oe", 0, 32'(dq_oe), 32'h1);
        rst_n = 1'b0;
        #1;
        check("rdrst_oe", 0, 32'(dq_oe), 32'h0);
        check("rdrst_dq", 0, 32'(dq_r), 32'h0);
        set_pins(1,1,1,0,0,18'h00004,16'h0000);
        m_reset();
        @(negedge clk) rst_n = 1'b1;

        // ---------------- reset during a write discards it ----------------
        set_pins(0,0,1,0,0,18'h00007,16'h7777);
        step(); step();
        set_pins(0,1,1,0,0,18'h00007,16'h0000);
        step();
        set_pins(0,0,1,0,0,18'h00007,16'h1111);
        step();
        rst_n = 1'b0;
        set_pins(1,1,1,0,0,18'h00007,16'h0000);
        m_reset();
        #2;
        @(negedge clk) rst_n = 1'b1;
        step();
        set_pins(0,1,0,0,0,18'h00007,16'h0000);
        for (int i = 0; i < 3; i++) step();
        check("wrrst_oe", 0, 32'(dq_oe), 32'h1);
        check("wrrst_dq", 0, 32'(dq_r), 32'h7777);
        set_pins(1,1,1,0,0,18'h00007,16'h0000);
        step();
        check("cen_oe", 0, 32'(dq_oe), 32'h0);

        // ---------------- randomized traffic against the model ----------------
        for (int a = 0; a < 8; a++) begin
            set_pins(0,0,1,0,0,18'(a),16'($urandom));
            step();
            set_pins(0,1,1,0,0,18'(a),16'h0000);
            step();
        end
        set_pins(0,1,0,0,0,18'h0,16'h0);
        for (int i = 0; i < 1500; i++) begin
            cen = ($urandom_range(0,15) == 0);
            wen = !($urandom_range(0,4) == 0);
            oen = ($urandom_range(0,5) == 0);
            if ($urandom_range(0,7) == 0) addr = 18'($urandom_range(0,7));
            if ($urandom_range(0,5) == 0) begin
                lbn = 1'($urandom_range(0,1));
                ubn = 1'($urandom_range(0,1));
            end
            dq_w = 16'($urandom);
            step();
            exp_q.push_back({12'h000, m_err, m_exp_oe, m_exp_dq});
            e = exp_q.pop_front();
            check("rnd_oe", i, 32'(dq_oe), 32'(e[16]));
            check("rnd_dq", i, 32'(dq_r), 32'(e[15:0]));
            check("rnd_err", i, 32'(err), 32'(e[19:17]));
        end

        // ---------------- protocol checker: oen low during a write ----------------
        rst_n = 1'b0;
        set_pins(1,1,1,0,0,18'h00002,16'h0000);
        m_reset();
        @(negedge clk) rst_n = 1'b1;
        step();
        check("chk_clear", 0, 32'(err), 32'h0);
        set_pins(0,0,0,0,0,18'h00002,16'h2222);
        step();
        check("chk_set", 0, 32'(err), 32'(EXP_CONTENTION));
        set_pins(0,1,1,0,0,18'h00002,16'h0000);
        step();
        check("chk_hold", 0, 32'(err), 32'(EXP_CONTENTION));
        set_pins(1,1,1,0,0,18'h00002,16'h0000);
        step();
        check("chk_hold", 1, 32'(err), 32'(EXP_CONTENTION));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
